// File: rtl/reduce_accel_pkg.sv
// Shared constants and types for the AXI-Lite reduction accelerator:
// register offsets, reduction modes, compute-FSM states and AXI response codes.
package reduce_accel_pkg;

  localparam int unsigned CTRL_OFS     = 'h00;
  localparam int unsigned STATUS_OFS   = 'h04;
  localparam int unsigned RESULT_OFS   = 'h08;
  localparam int unsigned OPERAND_BASE = 'h10;

  typedef enum logic [1:0] {
    MODE_SUM = 2'b00,
    MODE_SUB = 2'b01,
    MODE_XOR = 2'b10,
    MODE_MAX = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] DEADBEEF    = 32'hDEAD_BEEF;

endpackage

// File: rtl/axi_lite_regif.sv
// AXI-Lite slave front end: independent AW/W/B/AR/R handshakes, presenting a
// single-cycle register write strobe and a combinational register read port.
module axi_lite_regif
  import reduce_accel_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            wr_en,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb,
  input  logic                            wr_err,
  output logic                            rd_en,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   rd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   rd_data,
  input  logic                            rd_err
);

  logic                            aw_held;
  logic                            w_held;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   aw_addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_data_q;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb_q;

  // Readies are forced low while reset is asserted.
  assign s_axi_awready = !s_axi_areset && !aw_held && !s_axi_bvalid;
  assign s_axi_wready  = !s_axi_areset && !w_held  && !s_axi_bvalid;
  assign s_axi_arready = !s_axi_areset && !s_axi_rvalid;

  assign wr_en   = aw_held && w_held;
  assign wr_addr = aw_addr_q;
  assign wr_data = w_data_q;
  assign wr_strb = w_strb_q;

  assign rd_en   = s_axi_arvalid && s_axi_arready;
  assign rd_addr = s_axi_araddr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rdata  <= '0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end

      if (wr_en) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end

      if (rd_en) begin
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        s_axi_rvalid <= 1'b1;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_lite_reduce_accel.sv
// Reduction accelerator top: register file, address decode and a sequential
// one-operand-per-cycle reduction datapath behind an AXI-Lite slave.
module axi_lite_reduce_accel
  import reduce_accel_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_OPERANDS     = 4
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            irq
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int N     = C_NUM_OPERANDS;
  localparam int IDX_W = $clog2(N);
  localparam logic [AW-3:0]    NOPS     = (AW-2)'(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic          wr_en, wr_err, rd_en, rd_err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [SW-1:0] wr_strb;

  state_t           state, state_nxt;
  mode_t            mode;
  logic             irq_en, done, ovf, busy;
  logic [DW-1:0]    result, acc, acc_nxt, op_cur;
  logic [IDX_W-1:0] idx;
  logic [DW-1:0]    ops [N];
  logic             step_ovf;

  logic             wr_ctrl, wr_status, wr_result, wr_op, wr_ok, start;
  logic [AW-1:0]    wr_off, rd_off;
  logic [IDX_W-1:0] wr_op_idx, rd_op_idx;

  axi_lite_regif #(
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_S_AXI_DATA_WIDTH(DW)
  ) u_regif (
    .s_axi_aclk   (s_axi_aclk),
    .s_axi_areset (s_axi_areset),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb),
    .wr_err       (wr_err),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_err       (rd_err)
  );

  assign busy = (state == ST_RUN);
  assign irq  = done && irq_en;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_off    = wr_addr - AW'(OPERAND_BASE);
    wr_ctrl   = (wr_addr == AW'(CTRL_OFS));
    wr_status = (wr_addr == AW'(STATUS_OFS));
    wr_result = (wr_addr == AW'(RESULT_OFS));
    wr_op     = (wr_addr >= AW'(OPERAND_BASE)) && (wr_off[1:0] == 2'b00) &&
                (wr_off[AW-1:2] < NOPS);
    wr_op_idx = wr_off[IDX_W+1:2];
    // Operands and mode are frozen during RUN; a start-only CTRL write stays legal.
    wr_err    = !(wr_ctrl || wr_status || wr_result || wr_op) ||
                (busy && wr_op) ||
                (busy && wr_ctrl && wr_strb[0] && (wr_data[2:1] != mode));
    wr_ok     = wr_en && !wr_err;
    start     = wr_ok && wr_ctrl && wr_strb[0] && wr_data[0] && !busy;
  end

  always_comb begin
    rd_off    = rd_addr - AW'(OPERAND_BASE);
    rd_op_idx = rd_off[IDX_W+1:2];
    rd_data   = '0;
    rd_err    = 1'b0;
    if (rd_en) begin
      rd_data = DEADBEEF;
      rd_err  = 1'b1;
      if (rd_addr == AW'(CTRL_OFS)) begin
        rd_data = {{(DW-4){1'b0}}, irq_en, mode, 1'b0};
        rd_err  = 1'b0;
      end else if (rd_addr == AW'(STATUS_OFS)) begin
        rd_data = {{(DW-3){1'b0}}, ovf, done, busy};
        rd_err  = 1'b0;
      end else if (rd_addr == AW'(RESULT_OFS)) begin
        rd_data = result;
        rd_err  = 1'b0;
      end else if ((rd_addr >= AW'(OPERAND_BASE)) && (rd_off[1:0] == 2'b00) &&
                   (rd_off[AW-1:2] < NOPS)) begin
        rd_data = ops[rd_op_idx];
        rd_err  = 1'b0;
      end
    end
  end

  always_comb begin
    op_cur   = ops[idx];
    acc_nxt  = acc;
    step_ovf = 1'b0;
    case (mode)
      MODE_SUM: {step_ovf, acc_nxt} = {1'b0, acc} + {1'b0, op_cur};
      MODE_SUB: begin
        acc_nxt  = acc - op_cur;
        step_ovf = (acc < op_cur);
      end
      MODE_XOR: acc_nxt = acc ^ op_cur;
      MODE_MAX: acc_nxt = (op_cur > acc) ? op_cur : acc;
      default:  acc_nxt = acc;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (idx == LAST_IDX) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      mode   <= MODE_SUM;
      irq_en <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
      acc    <= '0;
      idx    <= '0;
      // NOTE: the operand array is software-visible state, so it is reset like any other register.
      for (int i = 0; i < N; i++) ops[i] <= '0;
    end else begin
      if (wr_ok) begin
        if (wr_ctrl && wr_strb[0]) begin
          mode   <= mode_t'(wr_data[2:1]);
          irq_en <= wr_data[3];
        end
        if (wr_status && wr_strb[0]) begin
          if (wr_data[1]) done <= 1'b0;
          if (wr_data[2]) ovf  <= 1'b0;
        end
        if (wr_op) begin
          for (int b = 0; b < SW; b++)
            if (wr_strb[b]) ops[wr_op_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      // Later assignments win, so a completing reduction overrides a same-edge W1C.
      if (start) begin
        acc  <= ops[0];
        idx  <= IDX_W'(1);
        done <= 1'b0;
        ovf  <= 1'b0;
      end else if (busy) begin
        acc <= acc_nxt;
        idx <= idx + 1'b1;
        if (step_ovf) ovf <= 1'b1;
        if (idx == LAST_IDX) begin
          result <= acc_nxt;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reduce_accel.sv
// Directed bench for axi_lite_reduce_accel: table of reduction vectors plus
// hand-written sequences for handshake ordering, errors, irq latency and reset.
module tb_axi_lite_reduce_accel;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        areset;
  logic [5:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, irq;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int failures = 0;

  int cyc = 0, commits = 0, bv_rise = 0, irq_rise = 0;
  logic bv_d = 1'b0, irq_d = 1'b0;

  always #5 clk = ~clk;

  axi_lite_reduce_accel #(
    .C_S_AXI_ADDR_WIDTH(6),
    .C_S_AXI_DATA_WIDTH(32),
    .C_NUM_OPERANDS(4)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (areset),
    .s_axi_awaddr (awaddr),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_bresp  (bresp),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_araddr (araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .irq          (irq)
  );

  // Port-level monitor: cycle stamps for bvalid and irq rising edges.
  always @(negedge clk) begin
    cyc   <= cyc + 1;
    bv_d  <= bvalid;
    irq_d <= irq;
    if (bvalid && !bv_d) begin
      commits <= commits + 1;
      bv_rise <= cyc;
    end
    if (irq && !irq_d) irq_rise <= cyc;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL timeout %s", name);
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int  n;
    bit  aw_done, w_done;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < TO) begin
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready)   w_done  = 1'b1;
      @(negedge clk);
      if (aw_done) awvalid = 1'b0;
      if (w_done)  wvalid  = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; n = 0;
    while (!bvalid && n < TO) begin
      @(negedge clk);
      n++;
    end
    if (!bvalid) timeout_fail("write_b");
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < TO) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1; n = 0;
    while (!rvalid && n < TO) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid) timeout_fail("read_r");
    d = rdata; r = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] st);
    logic [1:0] r;
    int n = 0;
    do begin
      axi_read(6'h04, st, r);
      n++;
    end while (!st[1] && n < 30);
    if (!st[1]) timeout_fail("wait_done");
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] op0, op1, op2, op3;
    logic [31:0] exp_res;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [31:0] rd, st;
    logic [1:0]  resp, rr;
    int          c0, n;

    vecs[0] = '{2'b00, 32'd10, 32'd32, 32'd5, 32'd3, 32'd50, 1'b0};
    vecs[1] = '{2'b01, 32'd5, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b1};
    vecs[2] = '{2'b10, 32'hF0F0_0000, 32'h0F0F_0000, 32'h0000_FFFF, 32'h1234_5678,
                32'hEDCB_A987, 1'b0};
    vecs[3] = '{2'b11, 32'd3, 32'hFFFF_0000, 32'd9, 32'd1, 32'hFFFF_0000, 1'b0};
    vecs[4] = '{2'b00, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd1, 1'b1};
    vecs[5] = '{2'b01, 32'd100, 32'd30, 32'd20, 32'd50, 32'd0, 1'b0};
    vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd1, 32'd2, 1'b1};

    areset = 1'b1; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_port_outputs",
          32'({awready, wready, arready, bvalid, rvalid, irq, bresp, rresp, rdata}), 32'h0);
    areset = 1'b0;

    axi_read(6'h04, rd, rr); check("reset_status", rd, 32'h0);
    axi_read(6'h08, rd, rr); check("reset_result", rd, 32'h0);
    axi_read(6'h00, rd, rr); check("reset_ctrl", rd, 32'h0);
    axi_read(6'h10, rd, rr); check("reset_op0", rd, 32'h0);

    // Byte strobes on an operand
    axi_write(6'h10, 32'h1122_3344, 4'hF, resp);
    axi_write(6'h10, 32'hAABB_CCDD, 4'b0010, resp);
    check("strb_resp", 32'(resp), 32'h0);
    axi_read(6'h10, rd, rr); check("strb_op0", rd, 32'h1122_CC44);

    for (int i = 0; i < 7; i++) begin
      axi_write(6'h10, vecs[i].op0, 4'hF, resp);
      axi_write(6'h14, vecs[i].op1, 4'hF, resp);
      axi_write(6'h18, vecs[i].op2, 4'hF, resp);
      axi_write(6'h1C, vecs[i].op3, 4'hF, resp);
      axi_write(6'h00, {29'b0, vecs[i].mode, 1'b1}, 4'hF, resp);
      wait_done(st);
      check($sformatf("v%0d_status", i), st, {29'b0, vecs[i].exp_ovf, 1'b1, 1'b0});
      axi_read(6'h08, rd, rr);
      check($sformatf("v%0d_result", i), rd, vecs[i].exp_res);
      axi_write(6'h04, 32'h6, 4'hF, resp);
      axi_read(6'h04, rd, rr);
      check($sformatf("v%0d_w1c", i), rd, 32'h0);
    end

    // AW three cycles ahead of W, bready withheld for two cycles
    @(negedge clk);
    awaddr = 6'h18; awvalid = 1'b1; bready = 1'b0; c0 = commits;
    check("hs_awready_idle", 32'(awready), 32'h1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hs_aw_held_%0d", k), 32'({awready, wready, bvalid}), 32'h2);
      if (k < 2) @(negedge clk);
    end
    wdata = 32'hCAFE_0002; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("hs_b_wait_%0d", k), 32'({awready, wready, bvalid, bresp}), 32'h4);
      if (k < 1) @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("hs_b_done", 32'({awready, wready, bvalid}), 32'h6);
    check("hs_commit_count", 32'(commits - c0), 32'h1);
    axi_read(6'h18, rd, rr); check("hs_op2", rd, 32'hCAFE_0002);

    // Unmapped and read-only offsets
    axi_write(6'h3C, 32'h1234_5678, 4'hF, resp); check("unmapped_wr_resp", 32'(resp), 32'h2);
    axi_read(6'h3C, rd, rr);
    check("unmapped_rd_resp", 32'(rr), 32'h2);
    check("unmapped_rd_data", rd, 32'hDEAD_BEEF);
    axi_write(6'h08, 32'h5555_5555, 4'hF, resp); check("result_wr_resp", 32'(resp), 32'h0);

    // Max mode with irq enabled: busy visible, irq N-1 cycles after start bvalid
    axi_write(6'h10, 32'd3, 4'hF, resp);
    axi_write(6'h14, 32'hFFFF_0000, 4'hF, resp);
    axi_write(6'h18, 32'd9, 4'hF, resp);
    axi_write(6'h1C, 32'd1, 4'hF, resp);
    axi_write(6'h00, 32'hF, 4'hF, resp);
    axi_read(6'h04, rd, rr); check("irq_busy_status", rd, 32'h1);
    n = 0;
    while (!irq && n < TO) begin
      @(negedge clk);
      n++;
    end
    check("irq_high", 32'(irq), 32'h1);
    check("irq_latency", 32'(irq_rise - bv_rise), 32'h3);
    axi_read(6'h08, rd, rr); check("irq_result", rd, 32'hFFFF_0000);
    axi_read(6'h00, rd, rr); check("irq_ctrl_readback", rd, 32'hE);
    axi_write(6'h04, 32'h2, 4'hF, resp);
    @(negedge clk);
    check("irq_cleared", 32'(irq), 32'h0);

    // Operand write while busy, start pipelined right behind it
    axi_write(6'h10, 32'd1, 4'hF, resp);
    axi_write(6'h14, 32'd2, 4'hF, resp);
    axi_write(6'h18, 32'd3, 4'hF, resp);
    axi_write(6'h1C, 32'd4, 4'hF, resp);
    @(negedge clk);
    awaddr = 6'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awaddr = 6'h14; wdata = 32'h55;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(awready && wready) && n < TO);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < TO) begin
      @(negedge clk);
      n++;
    end
    check("busy_op_wr_resp", 32'({bvalid, bresp}), 32'h6);
    @(negedge clk);
    bready = 1'b0;
    axi_read(6'h14, rd, rr); check("busy_op1_kept", rd, 32'd2);
    wait_done(st);
    axi_read(6'h08, rd, rr); check("busy_run_result", rd, 32'd10);

    // Reset in the middle of a reduction
    axi_write(6'h00, 32'h1, 4'hF, resp);
    areset = 1'b1;
    repeat (2) @(negedge clk);
    areset = 1'b0;
    axi_read(6'h04, rd, rr); check("midrun_reset_status", rd, 32'h0);
    axi_read(6'h08, rd, rr); check("midrun_reset_result", rd, 32'h0);
    axi_read(6'h14, rd, rr); check("midrun_reset_op1", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_reduce_accel.md
# axi_lite_reduce_accel

Parametrised AXI-Lite memory-mapped reduction accelerator for the Zynq PL, driven by PS software through MMIO. It holds C_NUM_OPERANDS operand registers and reduces them sequentially, one operand per clock, in a software-selected mode. It exposes busy/done/overflow status and a level interrupt. The AXI-Lite slave uses full, independent valid/ready handshake FSMs on all five channels.

## Interface
- C_S_AXI_ADDR_WIDTH, 6, byte address width; covers offsets 0x00–0x3C.
- C_S_AXI_DATA_WIDTH, 32, register and operand width; 32 only, so WSTRB stays 4 bits.
- C_NUM_OPERANDS, 4, number of operand registers; legal range 2–8.

Ports:
- s_axi_aclk  in  1  single clock.
- s_axi_areset  in  1  synchronous, active-high reset.
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR/1/1  write address channel.
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA/4/1/1  write data channel.
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axi_araddr/arvalid/arready  in/in/out  ADDR/1/1  read address channel.
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA/2/1/1  read data channel.
- irq  out  1  level interrupt, equal to done & irq_en.

## Operation
Register map:
- 0x00 CTRL:
  - bit0 start: write-1 pulse, reads 0.
  - bits[2:1] mode: 00 sum; 01 op0 minus the others; 10 xor; 11 unsigned max.
  - bit3 irq_en.
- 0x04 STATUS:
  - bit0 busy (RO).
  - bit1 done: sticky, write-1-to-clear.
  - bit2 ovf: sticky, write-1-to-clear.
- 0x08 RESULT (RO).
- 0x10 + 4·i: OPERAND i, for i < C_NUM_OPERANDS.

Any other offset is unmapped: reads return 0xDEAD_BEEF with SLVERR; writes are dropped with SLVERR.

WSTRB applies per byte to CTRL[3:1] and to operands. Writes to RESULT and STATUS bit0 are ignored with OKAY.

Compute FSM, states IDLE → RUN → IDLE:
- Start in IDLE loads acc ← op0, sets idx ← 1, clears done and ovf, sets busy.
- Each RUN cycle combines acc with op[idx], then idx increments.
- After idx = N-1: RESULT ← acc, done ← 1, busy ← 0.
- ovf sets on carry-out (sum) or borrow (sub) at any step. It stays 0 in the xor and max modes.
- Arithmetic wraps modulo 2^DATA.
- Start while busy is ignored; the write returns OKAY.
- An operand or CTRL-mode write while busy is dropped with SLVERR, so operands stay stable during RUN.
- A STATUS W1C on the same edge that sets done: the set wins.

Reset values:
- All registers and RESULT are 0.
- FSMs are idle.
- All ready, valid and irq outputs are 0.
- bresp and rresp are 00; rdata is 0.
- Reset mid-RUN aborts the reduction and leaves done = 0.

## Timing
Write path:
- awready is high when no AW is held and bvalid = 0. wready follows the same rule for W.
- AW and W are accepted independently, in either order or in the same cycle.
- The register commits on the edge ending the first cycle in which both are held. bvalid rises on that same edge.
- bvalid and bresp hold until bready. Both held flags clear at commit.

Read path:
- arready is high when rvalid = 0.
- rdata and rresp register on the AR handshake edge; rvalid is high the next cycle.
- rvalid holds until rready. arready is low while rvalid is high.
- Read and write traffic proceed concurrently. A read of STATUS on the edge of a commit returns the pre-commit value.

Compute latency:
- busy is high for exactly N-1 cycles, starting the cycle bvalid rises for the start write.
- done and RESULT are visible in the following cycle; irq rises in the same cycle.

## Structure
- Package reduce_accel_pkg holds:
  - offset constants: CTRL, STATUS, RESULT, OPERAND_BASE;
  - mode enum;
  - compute-state encoding;
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - DEADBEEF constant.
- One sub-module, axi_lite_regif, contains the handshake FSMs and presents wr_en/wr_addr/wr_data/wr_strb/wr_err and rd_en/rd_addr/rd_data/rd_err.
- The top level holds the register file and the reduction datapath.

## Test plan
- N=4, write ops 10, 32, 5, 3, then CTRL = 0x1 → busy for 3 cycles; RESULT = 50; done = 1; ovf = 0.
- Mode 01 with ops 5, 7, 0, 0 → RESULT = 0xFFFF_FFFE, ovf = 1. A W1C of 0x6 to STATUS then clears done and ovf.
- AW presented 3 cycles before W; bready held low for 2 cycles → single commit; bvalid held until bready; awready stays low throughout.
- Write to 0x3C and read 0x3C → both return SLVERR; read data = 0xDEAD_BEEF.
- Write OPERAND1 during busy → SLVERR and the operand is unchanged. Then assert s_axi_areset mid-RUN → busy = 0, done = 0, RESULT = 0.
- Mode 11 with irq_en = 1, ops 3, 0xFFFF_0000, 9, 1 → RESULT = 0xFFFF_0000; irq rises with done.
